// File: rtl/irq_ctrl.sv
// Fixed-priority interrupt controller. It synchronises the timer and external lines,
// latches or masks them, and serves PENDING/ENABLE/EDGE/CLAIM on an APB-style bus.
module irq_ctrl #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(32'h1100_8000),
   parameter int                    NUM_EXT    = 7
) (
   input  logic                  pclk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] paddr,
   input  logic [DATA_WIDTH-1:0] pdata,
   output logic [DATA_WIDTH-1:0] prdata,
   input  logic                  psel,
   input  logic                  penable,
   input  logic                  pwrite,
   input  logic [3:0]            pstb,
   output logic                  pready,
   output logic                  perr,
   input  logic                  timer_interrupt,
   input  logic [NUM_EXT-1:0]    ext_irq,
   output logic                  cpu_irq,
   output logic [4:0]            irq_id
);
   localparam int NS = NUM_EXT + 1;

   logic [NS-1:0]         sync1_r, s_r, prev_r;
   logic [NS-1:0]         pending_r, enable_r, edge_r, in_service_r;
   logic [NS-1:0]         rise_s, eligible_s, pending_next_s;
   logic [NS-1:0]         claim_set_s, claim_clr_s, done_clr_s, wmask_s;
   logic [4:0]            next_id_s;
   logic [ADDR_WIDTH-1:0] offset_s;
   logic [1:0]            reg_sel_s;
   logic                  access_s, addr_ok_s, err_s, rd_s, wr_s, claim_s, complete_s;
   logic [DATA_WIDTH-1:0] rdata_s, strobe_mask_s;
   logic                  unused_mask_s;

   // Bus decode: address check, access qualification and read mux
   always_comb begin
      access_s   = psel & penable & ~pready;
      offset_s   = paddr - BASE_ADDR;
      reg_sel_s  = offset_s[3:2];
      addr_ok_s  = (offset_s <= ADDR_WIDTH'(12)) && (offset_s[1:0] == 2'b00);
      err_s      = ~addr_ok_s | (pwrite & (reg_sel_s == 2'd0));
      wr_s       = access_s & ~err_s & pwrite;
      rd_s       = access_s & ~err_s & ~pwrite;
      claim_s    = rd_s & (reg_sel_s == 2'd3) & (irq_id != 5'd0);
      complete_s = wr_s & (reg_sel_s == 2'd3);
      strobe_mask_s = {{8{pstb[3]}}, {8{pstb[2]}}, {8{pstb[1]}}, {8{pstb[0]}}};
      wmask_s       = strobe_mask_s[NS-1:0];
      unused_mask_s = ^strobe_mask_s[DATA_WIDTH-1:NS];
      case (reg_sel_s)
         2'd0:    rdata_s = DATA_WIDTH'(pending_r);
         2'd1:    rdata_s = DATA_WIDTH'(enable_r);
         2'd2:    rdata_s = DATA_WIDTH'(edge_r);
         2'd3:    rdata_s = DATA_WIDTH'(irq_id);
         default: rdata_s = {DATA_WIDTH{1'b0}};
      endcase
   end

   // Per-source pending/claim/complete terms and lowest-index priority pick
   always_comb begin
      rise_s     = s_r & ~prev_r;
      eligible_s = pending_r & enable_r & ~in_service_r;
      next_id_s  = 5'd0;
      for (int i = NS - 1; i >= 0; i--) begin
         next_id_s = eligible_s[i] ? 5'(i + 1) : next_id_s;
      end
      for (int i = 0; i < NS; i++) begin
         claim_set_s[i] = claim_s && (irq_id == 5'(i + 1));
         claim_clr_s[i] = claim_set_s[i] & edge_r[i];
         done_clr_s[i]  = complete_s && (pdata == DATA_WIDTH'(i + 1));
         // a fresh edge in the claim cycle keeps the source pending
         pending_next_s[i] = edge_r[i] ? (rise_s[i] | (pending_r[i] & ~claim_clr_s[i])) : s_r[i];
      end
   end

   // State and registered outputs
   always_ff @(posedge pclk) begin
      if (rst) begin
         sync1_r      <= {NS{1'b0}};
         s_r          <= {NS{1'b0}};
         prev_r       <= {NS{1'b0}};
         pending_r    <= {NS{1'b0}};
         enable_r     <= {NS{1'b0}};
         edge_r       <= {NS{1'b0}};
         in_service_r <= {NS{1'b0}};
         cpu_irq      <= 1'b0;
         irq_id       <= 5'd0;
         pready       <= 1'b0;
         perr         <= 1'b0;
         prdata       <= {DATA_WIDTH{1'b0}};
      end else begin
         sync1_r   <= {ext_irq, timer_interrupt};
         s_r       <= sync1_r;
         prev_r    <= s_r;
         pending_r <= pending_next_s;
         if (wr_s && (reg_sel_s == 2'd1)) begin
            enable_r <= (enable_r & ~wmask_s) | (pdata[NS-1:0] & wmask_s);
         end
         if (wr_s && (reg_sel_s == 2'd2)) begin
            edge_r <= (edge_r & ~wmask_s) | (pdata[NS-1:0] & wmask_s);
         end
         in_service_r <= (in_service_r | claim_set_s) & ~done_clr_s;
         cpu_irq      <= |eligible_s;
         irq_id       <= next_id_s;
         pready       <= access_s;
         perr         <= access_s & err_s;
         prdata       <= rd_s ? rdata_s : {DATA_WIDTH{1'b0}};
      end
   end
endmodule

// File: tb/tb_irq_ctrl.sv
// Randomised bench for irq_ctrl. A cycle-level behavioural model checks every output on every
// cycle, and literal expectations from the directed scenarios pin down the model.
module tb_irq_ctrl;
   localparam int NUM_EXT = 7;
   localparam int NS = NUM_EXT + 1;
   localparam logic [31:0] BASE = 32'h1100_8000;

   logic pclk = 1'b0;
   logic rst, psel, penable, pwrite, pready, perr, timer_interrupt, cpu_irq;
   logic [31:0] paddr, pdata, prdata;
   logic [3:0] pstb;
   logic [NUM_EXT-1:0] ext_irq;
   logic [4:0] irq_id;

   int total = 0;
   int bad = 0;

   logic [NS-1:0] m_pend, m_en, m_edge, m_isv;
   logic [NS-1:0] raw1, raw2, raw3;   // input vector seen 1, 2, 3 edges ago
   logic m_irq, m_rdy, m_err;
   logic [4:0] m_id;
   logic [31:0] m_rdata;

   irq_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BASE_ADDR(BASE), .NUM_EXT(NUM_EXT)) dut (
      .pclk(pclk), .rst(rst), .paddr(paddr), .pdata(pdata), .prdata(prdata),
      .psel(psel), .penable(penable), .pwrite(pwrite), .pstb(pstb),
      .pready(pready), .perr(perr), .timer_interrupt(timer_interrupt),
      .ext_irq(ext_irq), .cpu_irq(cpu_irq), .irq_id(irq_id)
   );

   always #5 pclk = ~pclk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [NS-1:0] bwrite(input logic [NS-1:0] old, input logic [31:0] d,
                                            input logic [3:0] st);
      logic [31:0] w;
      w = 32'(old);
      for (int b = 0; b < 4; b++) if (st[b]) w[b*8 +: 8] = d[b*8 +: 8];
      return w[NS-1:0];
   endfunction

   // Advance the model across the coming edge, then compare all outputs at the negedge.
   task automatic tick();
      logic [NS-1:0] elig, rise, clr, pnew;
      logic [4:0] id;
      logic acc, err;
      logic [31:0] off, rd;
      if (rst) begin
         m_pend = '0; m_en = '0; m_edge = '0; m_isv = '0;
         raw1 = '0; raw2 = '0; raw3 = '0;
         m_irq = 1'b0; m_rdy = 1'b0; m_err = 1'b0; m_id = 5'd0; m_rdata = 32'd0;
      end else begin
         elig = m_pend & m_en & ~m_isv;
         id = 5'd0;
         for (int i = NS - 1; i >= 0; i--) if (elig[i]) id = 5'(i + 1);
         acc = psel && penable && !m_rdy;
         off = paddr - BASE;
         err = (off > 32'd12) || (off[1:0] != 2'b00) || (pwrite && off == 32'd0);
         rd = 32'd0;
         clr = '0;
         if (acc && !err && !pwrite) begin
            if (off == 32'd0) rd = 32'(m_pend);
            else if (off == 32'd4) rd = 32'(m_en);
            else if (off == 32'd8) rd = 32'(m_edge);
            else begin
               rd = 32'(m_id);
               if (m_id != 5'd0) begin
                  m_isv[int'(m_id) - 1] = 1'b1;
                  clr[int'(m_id) - 1] = m_edge[int'(m_id) - 1];
               end
            end
         end
         rise = raw2 & ~raw3;
         for (int i = 0; i < NS; i++)
            pnew[i] = m_edge[i] ? (rise[i] || (m_pend[i] && !clr[i])) : raw2[i];
         m_pend = pnew;
         if (acc && !err && pwrite) begin
            if (off == 32'd4) m_en = bwrite(m_en, pdata, pstb);
            else if (off == 32'd8) m_edge = bwrite(m_edge, pdata, pstb);
            else if (pdata >= 32'd1 && pdata <= 32'(NS)) m_isv[int'(pdata) - 1] = 1'b0;
         end
         m_rdy = acc;
         m_err = acc && err;
         m_rdata = (acc && !err && !pwrite) ? rd : 32'd0;
         m_irq = (elig != '0);
         m_id = id;
         raw3 = raw2; raw2 = raw1; raw1 = {ext_irq, timer_interrupt};
      end
      @(posedge pclk);
      @(negedge pclk);
      check("cpu_irq", 32'(cpu_irq), 32'(m_irq));
      check("irq_id", 32'(irq_id), 32'(m_id));
      check("pready", 32'(pready), 32'(m_rdy));
      check("perr", 32'(perr), 32'(m_err));
      check("prdata", prdata, m_rdata);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] st, output logic [31:0] rd, output logic er);
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pdata = data; pstb = st;
      tick();
      penable = 1'b1;
      tick();
      rd = prdata;
      er = perr;
      tick();
      psel = 1'b0; penable = 1'b0;
   endtask

   task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
      logic [31:0] d;
      logic e;
      apb(1'b0, addr, 32'd0, 4'hF, d, e);
      check(name, d, exp);
      check({name, "_perr"}, 32'(e), 32'd0);
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] st);
      logic [31:0] d;
      logic e;
      apb(1'b1, addr, data, st, d, e);
   endtask

   task automatic wr_err(input string name, input logic [31:0] addr);
      logic [31:0] d;
      logic e;
      apb(1'b1, addr, 32'hFFFF_FFFF, 4'hF, d, e);
      check(name, 32'(e), 32'd1);
   endtask

   initial begin
      logic [31:0] d;
      logic e;
      rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 32'd0; pdata = 32'd0;
      pstb = 4'h0; timer_interrupt = 1'b0; ext_irq = '0;
      ticks(2);
      rst = 1'b0;
      tick();

      rd_chk("rst_pending", BASE, 32'd0);
      rd_chk("rst_enable", BASE + 32'd4, 32'd0);
      rd_chk("rst_edge", BASE + 32'd8, 32'd0);
      rd_chk("rst_claim", BASE + 32'd12, 32'd0);

      // level timer: claim masks it, complete re-exposes it
      wr(BASE + 32'd4, 32'h3, 4'hF);
      wr(BASE + 32'd8, 32'h0, 4'hF);
      timer_interrupt = 1'b1;
      ticks(3);
      check("timer_lat3", 32'(cpu_irq), 32'd0);
      tick();
      check("timer_irq", 32'(cpu_irq), 32'd1);
      check("timer_id", 32'(irq_id), 32'd1);
      rd_chk("timer_claim", BASE + 32'd12, 32'd1);
      ticks(3);
      check("timer_masked", 32'(cpu_irq), 32'd0);
      wr(BASE + 32'd12, 32'd1, 4'h0);
      check("timer_complete", 32'(cpu_irq), 32'd1);
      timer_interrupt = 1'b0;
      ticks(4);

      // edge source on ext_irq[1] (ID 3)
      wr(BASE + 32'd8, 32'h4, 4'hF);
      wr(BASE + 32'd4, 32'h4, 4'hF);
      ext_irq[1] = 1'b1; tick(); ext_irq[1] = 1'b0;
      ticks(4);
      rd_chk("edge_pending", BASE, 32'h4);
      rd_chk("edge_claim", BASE + 32'd12, 32'd3);
      rd_chk("edge_cleared", BASE, 32'h0);
      ext_irq[1] = 1'b1; tick(); ext_irq[1] = 1'b0;
      ticks(4);
      rd_chk("edge_repend", BASE, 32'h4);
      check("edge_insvc", 32'(cpu_irq), 32'd0);
      wr(BASE + 32'd12, 32'd3, 4'hF);
      check("edge_complete", 32'(cpu_irq), 32'd1);
      rd_chk("edge_claim2", BASE + 32'd12, 32'd3);
      wr(BASE + 32'd12, 32'd3, 4'hF);

      // priority between timer and ext_irq[0]
      wr(BASE + 32'd8, 32'h0, 4'hF);
      wr(BASE + 32'd4, 32'h3, 4'hF);
      timer_interrupt = 1'b1; ext_irq[0] = 1'b1;
      ticks(4);
      check("prio_id1", 32'(irq_id), 32'd1);
      rd_chk("prio_claim1", BASE + 32'd12, 32'd1);
      check("prio_id2", 32'(irq_id), 32'd2);
      rd_chk("prio_claim2", BASE + 32'd12, 32'd2);
      check("prio_none", 32'(cpu_irq), 32'd0);
      rd_chk("prio_claim0", BASE + 32'd12, 32'd0);
      wr(BASE + 32'd12, 32'd1, 4'hF);
      check("prio_back1", 32'(irq_id), 32'd1);
      wr(BASE + 32'd12, 32'd2, 4'hF);
      timer_interrupt = 1'b0; ext_irq[0] = 1'b0;
      ticks(4);

      // byte strobes and error responses
      wr(BASE + 32'd4, 32'hFFFF_FFFF, 4'b0001);
      rd_chk("strobe_en", BASE + 32'd4, 32'h0000_00FF);
      wr_err("err_pending", BASE);
      wr_err("err_off10", BASE + 32'h10);
      wr_err("err_unalign", BASE + 32'h5);
      apb(1'b0, BASE + 32'h10, 32'd0, 4'hF, d, e);
      check("err_rd_perr", 32'(e), 32'd1);
      check("err_rd_data", d, 32'd0);
      rd_chk("err_en_kept", BASE + 32'd4, 32'h0000_00FF);
      rd_chk("err_edge_kept", BASE + 32'd8, 32'h0);

      // reset during a CLAIM access cycle
      timer_interrupt = 1'b1;
      ticks(4);
      check("rst_pre_irq", 32'(cpu_irq), 32'd1);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = BASE + 32'd12;
      tick();
      penable = 1'b1; rst = 1'b1;
      tick();
      check("rst_no_ready", 32'(pready), 32'd0);
      check("rst_irq_low", 32'(cpu_irq), 32'd0);
      rst = 1'b0; psel = 1'b0; penable = 1'b0;
      tick();
      check("rst_no_ready2", 32'(pready), 32'd0);
      wr(BASE + 32'd4, 32'h1, 4'hF);
      ticks(4);
      check("rst_not_insvc", 32'(cpu_irq), 32'd1);
      rd_chk("rst_claim_after", BASE + 32'd12, 32'd1);
      wr(BASE + 32'd12, 32'd1, 4'hF);
      timer_interrupt = 1'b0;

      // randomised traffic against the model
      for (int it = 0; it < 2000; it++) begin
         int op;
         if ($urandom_range(0, 3) == 0) begin
            int b;
            b = $urandom_range(0, NS - 1);
            if (b == 0) timer_interrupt = ~timer_interrupt;
            else ext_irq[b - 1] = ~ext_irq[b - 1];
         end
         op = $urandom_range(0, 11);
         case (op)
            5: apb(1'b0, BASE + 32'($urandom_range(0, 3) * 4), 32'd0, 4'hF, d, e);
            6: wr(BASE + 32'd4, $urandom, 4'($urandom_range(0, 15)));
            7: wr(BASE + 32'd8, $urandom, 4'($urandom_range(0, 15)));
            8, 9: apb(1'b0, BASE + 32'd12, 32'd0, 4'hF, d, e);
            10: wr(BASE + 32'd12, 32'($urandom_range(0, 10)), 4'($urandom_range(0, 15)));
            11: apb($urandom_range(0, 1) == 1, BASE + 32'($urandom_range(0, 20)), $urandom, 4'hF, d, e);
            default: tick();
         endcase
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
